// File: rtl/serial_shifter_pkg.sv
// serial_shifter_pkg: shared widths, shift/mode codes, FSM states and step-count helper
package serial_shifter_pkg;
    localparam int FULLW      = 32;
    localparam int WIDTH      = 8;
    localparam int SHIFTCODEW = 2;
    localparam int SHMODE_W   = 2;
    localparam int SSH_CNTW   = 6;
    localparam logic [SHIFTCODEW-1:0] LSL = 2'b00;
    localparam logic [SHIFTCODEW-1:0] LSR = 2'b01;
    localparam logic [SHIFTCODEW-1:0] ASR = 2'b10;
    localparam logic [SHIFTCODEW-1:0] ROR = 2'b11;
    localparam logic [SHMODE_W-1:0] SHMODE_IMM    = 2'd0;
    localparam logic [SHMODE_W-1:0] SHMODE_REG    = 2'd1;
    localparam logic [SHMODE_W-1:0] SHMODE_ROTIMM = 2'd2;
    typedef enum logic [1:0] {
        SSH_IDLE  = 2'd0,
        SSH_SHIFT = 2'd1,
        SSH_DONE  = 2'd2
    } ssh_state_t;
    function automatic logic [SSH_CNTW-1:0] clamp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] lim);
        return (a > lim) ? lim[SSH_CNTW-1:0] : a[SSH_CNTW-1:0];
    endfunction
    function automatic logic [SSH_CNTW-1:0] step_count(
        input logic [SHIFTCODEW-1:0] code,
        input logic [SHMODE_W-1:0]   mode,
        input logic [WIDTH-1:0]      shiftby
    );
        logic imm0;
        imm0 = (mode == SHMODE_IMM) && (shiftby == '0);
        return (code == LSL) ? clamp(shiftby, 8'd33) :
               (code == LSR) ? (imm0 ? 6'd32 : clamp(shiftby, 8'd33)) :
               (code == ASR) ? (imm0 ? 6'd32 : clamp(shiftby, 8'd32)) :
               imm0 ? 6'd1 :
               (mode == SHMODE_ROTIMM) ? {1'b0, shiftby[3:0], 1'b0} :
               (shiftby == '0) ? 6'd0 :
               (shiftby[4:0] == '0) ? 6'd32 : {1'b0, shiftby[4:0]};
    endfunction
endpackage

// File: rtl/serial_shifter_shift_step.sv
// shift_step: one-bit combinational shift/rotate step with carry-out
module shift_step
    import serial_shifter_pkg::*;
(
    input  logic [FULLW-1:0]      value,
    input  logic [SHIFTCODEW-1:0] code,
    input  logic                  rrx,
    input  logic                  carry_in,
    output logic [FULLW-1:0]      next_value,
    output logic                  carry_out
);
    logic fill;
    always_comb begin
        fill       = (code == ASR) ? value[FULLW-1] : (code == ROR) ? (rrx ? carry_in : value[0]) : 1'b0;
        next_value = (code == LSL) ? {value[FULLW-2:0], 1'b0} : {fill, value[FULLW-1:1]};
        carry_out  = (code == LSL) ? value[FULLW-1] : value[0];
    end
endmodule

// File: rtl/serial_shifter.sv
// serial_shifter: ARM shifter_operand computed one bit per cycle behind valid/ready handshakes
module serial_shifter
    import serial_shifter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FULLW-1:0]      in_rm,
    input  logic [SHIFTCODEW-1:0] in_shiftcode,
    input  logic [WIDTH-1:0]      in_shiftby,
    input  logic [SHMODE_W-1:0]   in_mode,
    input  logic                  in_carry,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FULLW-1:0]      out_result,
    output logic                  out_carry
);
    ssh_state_t state, state_nxt;
    logic [SSH_CNTW-1:0]   cnt, n;
    logic [SHIFTCODEW-1:0] code;
    logic                  rrx, accept, step_carry;
    logic [FULLW-1:0]      step_value;

    assign n         = step_count(in_shiftcode, in_mode, in_shiftby);
    assign in_ready  = (state == SSH_IDLE) || ((state == SSH_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == SSH_DONE);

    shift_step u_step (
        .value      (out_result),
        .code       (code),
        .rrx        (rrx),
        .carry_in   (out_carry),
        .next_value (step_value),
        .carry_out  (step_carry)
    );

    always_comb begin
        state_nxt = state;
        state_nxt = accept ? ((n == '0) ? SSH_DONE : SSH_SHIFT) :
                    (state == SSH_SHIFT) ? ((cnt == 6'd1) ? SSH_DONE : SSH_SHIFT) :
                    ((state == SSH_DONE) && out_ready) ? SSH_IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SSH_IDLE;
            cnt        <= '0;
            code       <= LSL;
            rrx        <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt        <= n;
                code       <= in_shiftcode;
                rrx        <= (in_shiftcode == ROR) && (in_mode == SHMODE_IMM) && (in_shiftby == '0);
                out_result <= in_rm;
                out_carry  <= in_carry;
            end else if (state == SSH_SHIFT) begin
                cnt        <= cnt - 6'd1;
                out_result <= step_value;
                out_carry  <= step_carry;
            end
        end
    end
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: scoreboard bench comparing against an ARM shifter reference model
module tb_serial_shifter;
    import serial_shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_carry, out_valid, out_ready, out_carry;
    logic [31:0] in_rm, out_result;
    logic [1:0]  in_shiftcode, in_mode;
    logic [7:0]  in_shiftby;

    typedef struct {
        logic [31:0] r;
        logic        c;
        int          lat;
    } exp_t;
    exp_t sb_q[$];
    int checks = 0;
    int passed = 0;

    serial_shifter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rm(in_rm), .in_shiftcode(in_shiftcode), .in_shiftby(in_shiftby),
        .in_mode(in_mode), .in_carry(in_carry), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ARM shifter_operand semantics written directly from amounts, returns {carry, result}
    function automatic logic [32:0] model(input logic [31:0] rm, input logic [1:0] code,
                                          input logic [1:0] mode, input logic [7:0] sb, input logic cin);
        int a;
        int rot;
        logic [31:0] r;
        logic c;
        r = rm;
        c = cin;
        if (code == LSL) begin
            a = sb;
            if (a == 0) begin r = rm; c = cin; end
            else if (a < 32) begin r = rm << a; c = rm[32-a]; end
            else if (a == 32) begin r = 0; c = rm[0]; end
            else begin r = 0; c = 0; end
        end else if (code == LSR || code == ASR) begin
            a = (mode == SHMODE_IMM && sb == 0) ? 32 : int'(sb);
            if (a == 0) begin r = rm; c = cin; end
            else if (a < 32) begin
                r = (code == ASR) ? 32'($signed(rm) >>> a) : rm >> a;
                c = rm[a-1];
            end else if (code == ASR) begin r = {32{rm[31]}}; c = rm[31]; end
            else if (a == 32) begin r = 0; c = rm[31]; end
            else begin r = 0; c = 0; end
        end else if (mode == SHMODE_IMM && sb == 0) begin
            r = {cin, rm[31:1]};
            c = rm[0];
        end else begin
            rot = (mode == SHMODE_ROTIMM) ? 2 * int'(sb[3:0]) : int'(sb[4:0]);
            if ((mode == SHMODE_ROTIMM && rot == 0) || (mode != SHMODE_ROTIMM && sb == 0)) begin
                r = rm; c = cin;
            end else if (rot == 0) begin
                r = rm; c = rm[31];
            end else begin
                r = (rm >> rot) | (rm << (32 - rot));
                c = r[31];
            end
        end
        return {c, r};
    endfunction

    task automatic issue(input logic [31:0] rm, input logic [1:0] code, input logic [1:0] mode,
                         input logic [7:0] sb, input logic cin, input int lat);
        exp_t e;
        logic [32:0] m;
        m = model(rm, code, mode, sb, cin);
        e.r = m[31:0];
        e.c = m[32];
        e.lat = lat;
        sb_q.push_back(e);
        in_rm = rm;
        in_shiftcode = code;
        in_mode = mode;
        in_shiftby = sb;
        in_carry = cin;
        in_valid = 1'b1;
    endtask

    task automatic collect(input string name);
        exp_t e;
        int lat;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) $display("FAIL %s_valid: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
        else passed++;
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL %s_queue: scoreboard empty, required an entry", name);
            return;
        end
        e = sb_q.pop_front();
        if (e.lat >= 0) begin
            checks++;
            if (lat != e.lat) $display("FAIL %s_latency: got %0d, required %0d", name, lat, e.lat);
            else passed++;
        end
        checks++;
        if (out_result !== e.r) $display("FAIL %s_result: got %h, required %h", name, out_result, e.r);
        else passed++;
        checks++;
        if (out_carry !== e.c) $display("FAIL %s_carry: got %b, required %b", name, out_carry, e.c);
        else passed++;
    endtask

    task automatic run_op(input logic [31:0] rm, input logic [1:0] code, input logic [1:0] mode,
                          input logic [7:0] sb, input logic cin, input int lat, input string name);
        @(negedge clk);
        issue(rm, code, mode, sb, cin, lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(name);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_rm = '0; in_shiftcode = '0; in_mode = '0; in_shiftby = '0; in_carry = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_handshake: valid=%b ready=%b, required 0/1", out_valid, in_ready);
        else passed++;
        checks++;
        if (out_result !== 32'h0 || out_carry !== 1'b0) $display("FAIL reset_data: result=%h carry=%b, required 0/0", out_result, out_carry);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_op(32'h8000_0001, LSR, SHMODE_IMM,    8'd0,   1'b0, 33, "lsr32");
        run_op(32'h8000_0000, ASR, SHMODE_REG,    8'd200, 1'b0, 33, "asr_sat");
        run_op(32'h0000_0003, ROR, SHMODE_IMM,    8'd0,   1'b1, 2,  "rrx");
        run_op(32'h0000_00FF, ROR, SHMODE_ROTIMM, 8'd4,   1'b0, 9,  "rotimm8");
        run_op(32'hDEAD_BEEF, ROR, SHMODE_ROTIMM, 8'd0,   1'b0, 1,  "rotimm0");
        run_op(32'hFFFF_FFFF, LSL, SHMODE_REG,    8'd40,  1'b1, 34, "lsl_sat");
        run_op(32'h0000_0001, LSL, SHMODE_REG,    8'd32,  1'b0, 33, "lsl32");
        run_op(32'h8000_0001, ROR, SHMODE_REG,    8'd32,  1'b0, 33, "ror32");
        run_op(32'h1234_5678, LSL, SHMODE_REG,    8'd0,   1'b1, 1,  "reg0");
        run_op(32'h8765_4321, ASR, 2'd3,          8'd7,   1'b0, 8,  "mode3");
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        @(negedge clk);
        issue(32'h0000_00F1, LSL, SHMODE_IMM, 8'd4, 1'b1, 5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect("lsl4");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'h0000_0F10 || out_carry !== 1'b0)
                $display("FAIL stall_hold: valid=%b result=%h carry=%b, required 1/00000f10/0", out_valid, out_result, out_carry);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL stall_release: out_valid=%b, required 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        in_rm = 32'hA5A5_A5A5; in_shiftcode = LSR; in_mode = SHMODE_IMM; in_shiftby = 8'd0; in_carry = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_carry !== 1'b0)
            $display("FAIL reset_mid: valid=%b ready=%b result=%h carry=%b, required 0/1/0/0", out_valid, in_ready, out_result, out_carry);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL reset_discard: out_valid rose after reset, required no output");
        else passed++;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        @(negedge clk);
        issue(32'h0000_0001, LSL, SHMODE_IMM, 8'd4, 1'b0, 5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect("b2b_a");
        issue(32'h0000_1234, ROR, SHMODE_ROTIMM, 8'd0, 1'b1, 1);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect("b2b_b");
        issue(32'h0000_000F, LSR, SHMODE_REG, 8'd2, 1'b0, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drop: out_valid=%b, required 0", out_valid);
        else passed++;
        collect("b2b_c");
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [1:0] mode;
        logic [7:0] sb;
        for (int i = 0; i < 16; i++) begin
            mode = 2'($urandom_range(0, 3));
            sb = (i % 4 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op($urandom, 2'($urandom_range(0, 3)), mode, sb, 1'($urandom_range(0, 1)), -1, "random");
        end
    endtask

    initial begin
        test_reset;
        test_stall;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
